mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory port with a
// single outstanding transaction and round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_req_i,
    output logic          i_gnt_o,
    output logic          i_rvalid_o,
    input  logic [AW-1:0] i_addr_i,
    input  logic          d_req_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    input  logic [AW-1:0] d_addr_i,
    input  logic          d_we_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          m_req_o,
    input  logic          m_gnt_i,
    input  logic          m_rvalid_i,
    output logic [AW-1:0] m_addr_o,
    output logic          m_we_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i,
    output logic          err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e state_q, state_d;
    // Master encoding for owner/last: 0 = instruction, 1 = data.
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   err_q, err_d;
    logic   any_req, sel_d, cur_d, cur_req, grant, active;

    assign any_req = i_req_i | d_req_i;
    // On a tie the master that was not granted last wins.
    assign sel_d   = d_req_i & (~i_req_i | ~last_q);
    assign cur_d   = (state_q == StIdle) ? sel_d : owner_q;
    assign grant   = cur_req & m_gnt_i & ~rst_i;
    assign active  = (state_q != StIdle) | any_req;

    always_comb begin
        cur_req = 1'b0;
        unique case (state_q)
            StIdle:  cur_req = any_req;
            StReq:   cur_req = owner_q ? d_req_i : i_req_i;
            StResp:  cur_req = 1'b0;
            default: cur_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = sel_d;
                    state_d = m_gnt_i ? StResp : StReq;
                end
            end
            StReq: begin
                if (!cur_req) begin
                    state_d = StIdle;
                end else if (m_gnt_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (m_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant) begin
            last_d = cur_d;
        end
        // A response with nothing outstanding is a protocol error; it is never forwarded.
        err_d = err_q | (m_rvalid_i & (state_q != StResp));
    end

    always_comb begin
        m_req_o    = cur_req & ~rst_i;
        i_gnt_o    = grant & ~cur_d;
        d_gnt_o    = grant & cur_d;
        i_rvalid_o = (state_q == StResp) & m_rvalid_i & ~owner_q;
        d_rvalid_o = (state_q == StResp) & m_rvalid_i & owner_q;
        m_addr_o   = '0;
        m_we_o     = 1'b0;
        m_wdata_o  = '0;
        if (active) begin
            m_addr_o  = cur_d ? d_addr_i : i_addr_i;
            m_we_o    = cur_d & d_we_i;
            m_wdata_o = cur_d ? d_wdata_i : '0;
        end
        rdata_o = m_rdata_i;
        err_o   = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grant/response events are queued by
// the stimulus and checked by an independent monitor sampling on the falling edge.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i, d_req_i, d_we_i;
    logic [AW-1:0] i_addr_i, d_addr_i;
    logic [DW-1:0] d_wdata_i, m_rdata_i;
    logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
    logic [DW-1:0] rdata_o, m_wdata_o;
    logic          m_req_o, m_gnt_i, m_rvalid_i, m_we_o, err_o;
    logic [AW-1:0] m_addr_o;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_req_i    (i_req_i),
        .i_gnt_o    (i_gnt_o),
        .i_rvalid_o (i_rvalid_o),
        .i_addr_i   (i_addr_i),
        .d_req_i    (d_req_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_addr_i   (d_addr_i),
        .d_we_i     (d_we_i),
        .d_wdata_i  (d_wdata_i),
        .rdata_o    (rdata_o),
        .m_req_o    (m_req_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_wdata_o  (m_wdata_o),
        .m_rdata_i  (m_rdata_i),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // flags = {i_gnt, d_gnt, i_rvalid, d_rvalid}
    typedef struct packed {
        logic [3:0]    flags;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input logic [3:0] flags, input logic [DW-1:0] data);
        exp_t e;
        e.flags = flags;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: any grant or response must match the next queued expectation.
    always @(negedge clk_i) begin
        logic [3:0]    f;
        logic [DW-1:0] d;
        exp_t          e;
        f = {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o};
        if (f != 4'b0000) begin
            d = (f[1] | f[0]) ? rdata_o : '0;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {28'd0, f, d}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("event", {28'd0, f, d}, {28'd0, e.flags, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; i_req_i = 1'b1; d_req_i = 1'b0; d_we_i = 1'b0;
        i_addr_i = 32'h100; d_addr_i = '0; d_wdata_i = '0;
        m_gnt_i = 1'b1; m_rvalid_i = 1'b0; m_rdata_i = '0;
        #2;
        // Reset state: requests and grants present, all outputs suppressed.
        check("rst_outputs", {59'd0, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, m_req_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        i_req_i = 1'b0; m_gnt_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();

        // Single instruction read, granted immediately.
        i_req_i = 1'b1; i_addr_i = 32'h100; m_gnt_i = 1'b1;
        expect_ev(4'b1000, '0);
        #1;
        check("i_req_passthru", {63'd0, m_req_o}, 64'd1);
        check("i_addr", {32'd0, m_addr_o}, 64'h100);
        tick();
        i_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
        expect_ev(4'b0010, 32'hDEADBEEF);
        #1;
        check("no_req_in_resp", {63'd0, m_req_o}, 64'd0);
        tick();
        m_rvalid_i = 1'b0;
        tick();

        // Both requesting from reset with an always-granting memory: D, I, D, I.
        rst_i = 1'b1; #1; rst_i = 1'b0;
        i_req_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h40; m_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_rvalid_i = 1'b0;
            expect_ev((k % 2 == 0) ? 4'b0100 : 4'b1000, '0);
            tick();
            m_rvalid_i = 1'b1; m_rdata_i = 32'hA000 + k;
            expect_ev((k % 2 == 0) ? 4'b0001 : 4'b0010, 32'hA000 + k);
            tick();
        end
        i_req_i = 1'b0; d_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
        tick();

        // Data write stalled three cycles; instruction arrives late and must wait.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h55;
        i_addr_i = 32'h300;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) i_req_i = 1'b1;
            if (c == 3) begin
                m_gnt_i = 1'b1;
                expect_ev(4'b0100, '0);
            end
            #1;
            check("wr_hold_bus", {m_req_o, m_we_o, m_addr_o[29:0], m_wdata_o}, {2'b11, 30'h200, 32'h55});
            tick();
        end
        d_req_i = 1'b0; d_we_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = '0;
        expect_ev(4'b0001, '0);
        #1;
        check("bubble_after_grant", {63'd0, m_req_o}, 64'd0);
        tick();
        m_rvalid_i = 1'b0; m_gnt_i = 1'b1;
        expect_ev(4'b1000, '0);
        #1;
        check("i_served_next", {31'd0, m_req_o, m_addr_o}, {31'd0, 1'b1, 32'h300});
        tick();
        i_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h1234;
        expect_ev(4'b0010, 32'h1234);
        tick();
        m_rvalid_i = 1'b0;
        tick();

        // Spurious response in IDLE: not routed, sticky error.
        check("err_before", {63'd0, err_o}, 64'd0);
        m_rvalid_i = 1'b1;
        tick();
        m_rvalid_i = 1'b0;
        check("err_set", {63'd0, err_o}, 64'd1);
        tick(); tick();
        check("err_sticky", {63'd0, err_o}, 64'd1);
        rst_i = 1'b1; #1;
        check("err_cleared", {63'd0, err_o}, 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Reset during RESP discards the response; the late one flags an error.
        i_req_i = 1'b1; i_addr_i = 32'h500; m_gnt_i = 1'b1;
        expect_ev(4'b1000, '0);
        tick();
        i_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hBAD;
        rst_i = 1'b1;
        #1;
        check("rst_async_kill", {60'd0, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o}, 64'd0);
        tick();
        m_rvalid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        m_rvalid_i = 1'b1;
        #1;
        check("late_rv_not_routed", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
        tick();
        m_rvalid_i = 1'b0;
        check("late_rv_err", {63'd0, err_o}, 64'd1);
        tick(); tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
